// File: rtl/pitch_cv_pkg.sv
`default_nettype none
// ============================================================================
// pitch_cv_pkg : shared state encoding and elaboration-time constants
//                for the 1V/oct CV to transpose pitch converter
// Revision 1.0
// ============================================================================
package pitch_cv_pkg;

  localparam int CV_PER_OCT_DEFAULT = 4000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLAMP  = 3'd1,
    DIVIDE = 3'd2,
    INDEX  = 3'd3,
    LOOKUP = 3'd4,
    SHIFT  = 3'd5,
    UPDATE = 3'd6
  } state_t;

  // Fixed-point reciprocal that maps an in-octave remainder onto a ROM index.
  function automatic int recip(input int lut_bits, input int cv_per_oct);
    longint num;
    num = longint'(1) << (16 + lut_bits);
    return int'(num / longint'(cv_per_oct));
  endfunction

  // round(2^(w-1) * 2^(idx / 2^lut_bits))
  function automatic int exp2_entry(input int idx, input int lut_bits, input int w);
    real scale;
    real frac;
    scale = real'(longint'(1) << (w - 1));
    frac  = real'(idx) / real'(longint'(1) << lut_bits);
    return $rtoi(scale * (2.0 ** frac) + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/exp2_rom.sv
`default_nettype none
// ============================================================================
// exp2_rom : 2^LUT_BITS x (W+1) fractional-octave exp2 table, registered read
// Revision 1.0
// ============================================================================
module exp2_rom
  import pitch_cv_pkg::*;
#(
  parameter int W        = 16,
  parameter int LUT_BITS = 8
) (
  input  logic                clk,
  input  logic [LUT_BITS-1:0] addr,
  output logic [W:0]          data
);

  localparam int c_depth = 1 << LUT_BITS;

  logic [W:0] w_rom [c_depth];

  for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
    assign w_rom[gi] = (W+1)'(exp2_entry(gi, LUT_BITS, W));
  end

  always_ff @(posedge clk) begin
    data <= w_rom[addr];
  end

endmodule
`default_nettype wire

// File: rtl/pitch_cv_rate.sv
`default_nettype none
// ============================================================================
// pitch_cv_rate : per-sample 1V/oct CV to playback ratio and transpose pitch
//                 word (clamp, octave divide, exp2 lookup, shift)
// Revision 1.0
// ============================================================================
module pitch_cv_rate
  import pitch_cv_pkg::*;
#(
  parameter int W          = 16,
  parameter int CV_PER_OCT = CV_PER_OCT_DEFAULT,
  parameter int LUT_BITS   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_clk,
  input  logic [W-1:0] cv_in,
  output logic [W-1:0] pitch_out,
  output logic [W:0]   ratio_out,
  output logic         valid,
  output logic         busy
);

  localparam int            c_lo      = -8 * CV_PER_OCT;
  localparam int            c_hi      = CV_PER_OCT;
  localparam int            c_uw      = $clog2(9 * CV_PER_OCT + 1);
  localparam int            c_recip   = recip(LUT_BITS, CV_PER_OCT);
  localparam int            c_idx_max = (1 << LUT_BITS) - 1;
  localparam logic [c_uw-1:0]     c_step    = c_uw'(CV_PER_OCT);
  localparam logic [LUT_BITS-1:0] c_idx_sat = LUT_BITS'(c_idx_max);
  localparam logic [W:0]    c_unity   = (W+1)'(1) << (W - 1);
  localparam logic [W+1:0]  c_unity_x = (W+2)'(1) << (W - 1);
  localparam logic [3:0]    c_k_top   = 4'd9;
  localparam logic [3:0]    c_k_zero  = 4'd8;

  state_t              r_state;
  state_t              w_next;
  logic                r_prev;
  logic [W-1:0]        r_cv;
  logic [c_uw-1:0]     r_u;
  logic [3:0]          r_k;
  logic [LUT_BITS-1:0] r_idx;
  logic [W:0]          r_ratio;

  logic                w_start;
  logic                w_ge;
  int                  w_cv_s;
  int                  w_c;
  logic [c_uw-1:0]     w_u_init;
  logic [63:0]         w_quot;
  logic [LUT_BITS-1:0] w_idx;
  logic [W:0]          w_e;
  logic [W:0]          w_ratio;

  assign w_start = sample_clk && !r_prev && (r_state == IDLE);
  assign w_ge    = (r_u >= c_step);

  always_comb begin
    w_cv_s = int'($signed(r_cv));
    w_c    = w_cv_s;
    if (w_cv_s < c_lo) begin
      w_c = c_lo;
    end else if (w_cv_s > c_hi) begin
      w_c = c_hi;
    end
  end

  assign w_u_init = c_uw'(w_c - c_lo);

  assign w_quot = (64'(r_u) * 64'(c_recip)) >> 16;
  assign w_idx  = (w_quot > 64'(c_idx_max)) ? c_idx_sat : w_quot[LUT_BITS-1:0];

  // k = 9 means octave +1; the clamp guarantees a zero remainder there.
  assign w_ratio = (r_k == c_k_top) ? (w_e << 1) : (w_e >> (c_k_zero - r_k));

  exp2_rom #(
    .W        (W),
    .LUT_BITS (LUT_BITS)
  ) u_rom (
    .clk  (clk),
    .addr (r_idx),
    .data (w_e)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    case (r_state)
      IDLE:    if (w_start) w_next = CLAMP;
      CLAMP:   w_next = DIVIDE;
      DIVIDE:  if (!w_ge) w_next = INDEX;
      INDEX:   w_next = LOOKUP;
      LOOKUP:  w_next = SHIFT;
      SHIFT:   w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev    <= 1'b1;
      r_cv      <= '0;
      r_u       <= '0;
      r_k       <= '0;
      r_idx     <= '0;
      r_ratio   <= c_unity;
      ratio_out <= c_unity;
      pitch_out <= '0;
      valid     <= 1'b0;
    end else begin
      r_prev <= sample_clk;
      valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) r_cv <= cv_in;
        end
        CLAMP: begin
          r_u <= w_u_init;
          r_k <= '0;
        end
        DIVIDE: begin
          if (w_ge) begin
            r_u <= r_u - c_step;
            r_k <= r_k + 4'd1;
          end
        end
        INDEX: begin
          r_idx <= w_idx;
        end
        SHIFT: begin
          r_ratio <= w_ratio;
        end
        UPDATE: begin
          ratio_out <= r_ratio;
          pitch_out <= W'(c_unity_x - {1'b0, r_ratio});
          valid     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
